// File: rtl/mem_burst_master_if.sv
// Client request/data handshake and main-memory pin bundle for mem_burst_master.
// The master modport is the burst master. The slave modport is the client plus the memory.
interface mem_burst_master_if #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int ACCESS_SIZE  = 2
) ();
  logic                    req_valid;
  logic                    req_ready;
  logic [ADDRESS_SIZE-1:0] req_addr;
  logic [ACCESS_SIZE-1:0]  req_size;
  logic                    req_wren;
  logic [DATA_SIZE-1:0]    wdata;
  logic                    wdata_pop;
  logic [DATA_SIZE-1:0]    rd_data;
  logic                    rd_valid;
  logic                    rd_last;
  logic                    done;
  logic                    err;
  logic [ADDRESS_SIZE-1:0] mem_addr;
  logic [DATA_SIZE-1:0]    mem_d_in;
  logic [DATA_SIZE-1:0]    mem_d_out;
  logic [ACCESS_SIZE-1:0]  mem_acc_size;
  logic                    mem_wren;
  logic                    mem_enable;
  logic                    mem_busy;

  modport master (
    input  req_valid, req_addr, req_size, req_wren, wdata, mem_d_out, mem_busy,
    output req_ready, wdata_pop, rd_data, rd_valid, rd_last, done, err,
           mem_addr, mem_d_in, mem_acc_size, mem_wren, mem_enable
  );

  modport slave (
    output req_valid, req_addr, req_size, req_wren, wdata, mem_d_out, mem_busy,
    input  req_ready, wdata_pop, rd_data, rd_valid, rd_last, done, err,
           mem_addr, mem_d_in, mem_acc_size, mem_wren, mem_enable
  );
endinterface

// File: rtl/mem_burst_master.sv
// Burst initiator for the main-memory port: range-checks a request, then runs N beats.
// The memory's busy signal is used only to detect protocol errors.
module mem_burst_master #(
  parameter int                      ADDRESS_SIZE  = 32,
  parameter int                      DATA_SIZE     = 32,
  parameter int                      ACCESS_SIZE   = 2,
  parameter logic [ADDRESS_SIZE-1:0] START_ADDRESS = 32'h8002_0000,
  parameter int unsigned             MEM_SIZE      = 1048576
) (
  input logic             clk,
  input logic             reset,
  mem_burst_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, BURST, FINISH} state_t;

  state_t                  state_q;
  logic [4:0]              cnt_q;
  logic [4:0]              last_q;
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic [ACCESS_SIZE-1:0]  size_q;
  logic                    wren_q;
  logic                    err_q;
  logic                    req_ready_q;
  logic                    mem_enable_q;
  logic                    wdata_pop_q;
  logic                    rd_valid_q;
  logic                    rd_last_q;
  logic                    done_q;

  logic [4:0]              last_d;
  logic [6:0]              nbytes_d;
  logic [ADDRESS_SIZE:0]   end_d;
  logic                    req_ok_d;

  // The bound check uses one extra bit so an address near the top of the space cannot wrap.
  always_comb begin
    last_d   = 5'd0;
    nbytes_d = 7'd4;
    case (bus.req_size)
      2'b01:   begin last_d = 5'd3;  nbytes_d = 7'd16; end
      2'b10:   begin last_d = 5'd7;  nbytes_d = 7'd32; end
      2'b11:   begin last_d = 5'd15; nbytes_d = 7'd64; end
      default: begin last_d = 5'd0;  nbytes_d = 7'd4;  end
    endcase
    end_d    = {1'b0, bus.req_addr} - {1'b0, START_ADDRESS} + (ADDRESS_SIZE+1)'(nbytes_d);
    req_ok_d = (bus.req_addr[1:0] == 2'b00) &&
               (bus.req_addr >= START_ADDRESS) &&
               (end_d <= (ADDRESS_SIZE+1)'(MEM_SIZE));
  end

  // NOTE: every output register has an async reset, so mem_enable drops as soon as reset rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_q       <= '0;
      addr_q       <= '0;
      size_q       <= '0;
      wren_q       <= 1'b0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      mem_enable_q <= 1'b0;
      wdata_pop_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q      <= bus.req_addr;
            size_q      <= bus.req_size;
            wren_q      <= bus.req_wren;
            last_q      <= last_d;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            if (req_ok_d) begin
              state_q      <= BURST;
              mem_enable_q <= 1'b1;
              wdata_pop_q  <= bus.req_wren;
            end else begin
              state_q <= FINISH;
              err_q   <= 1'b1;
              done_q  <= 1'b1;
            end
          end
        end
        BURST: begin
          cnt_q      <= cnt_q + 5'd1;
          rd_valid_q <= !wren_q;
          rd_last_q  <= !wren_q && (cnt_q == last_q);
          // The memory must report busy on every interior beat of a burst.
          if ((cnt_q != 5'd0) && (cnt_q != last_q) && !bus.mem_busy) err_q <= 1'b1;
          if (cnt_q == last_q) begin
            state_q      <= FINISH;
            mem_enable_q <= 1'b0;
            wdata_pop_q  <= 1'b0;
            done_q       <= 1'b1;
          end
        end
        FINISH: begin
          state_q     <= IDLE;
          done_q      <= 1'b0;
          err_q       <= 1'b0;
          rd_valid_q  <= 1'b0;
          rd_last_q   <= 1'b0;
          req_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.mem_enable   = mem_enable_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_acc_size = size_q;
  assign bus.mem_wren     = wren_q & mem_enable_q;
  assign bus.mem_d_in     = wdata_pop_q ? bus.wdata : DATA_SIZE'(0);
  assign bus.wdata_pop    = wdata_pop_q;
  assign bus.rd_data      = rd_valid_q ? bus.mem_d_out : DATA_SIZE'(0);
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_last      = rd_last_q;
  assign bus.done         = done_q;
  assign bus.err          = done_q & err_q;

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master against a small word-indexed memory model.
// The memory model advances its own index on each enabled beat.
module tb_mem_burst_master;

  localparam logic [31:0] START = 32'h8002_0000;
  localparam logic [31:0] MSIZE = 32'h0010_0000;

  logic clk = 1'b0;
  logic reset;
  logic busy_kill;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_rd [0:15];

  always #5 clk = ~clk;

  mem_burst_master_if bus ();

  mem_burst_master dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: word i starts as C000_0000+i. A burst begins at mem_addr and steps one word per beat.
  logic [31:0] mem_q [0:63];
  logic        mem_init = 1'b0;
  logic        was_en   = 1'b0;
  int unsigned mem_idx  = 0;
  int unsigned w;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem_q[i] <= 32'hC000_0000 + 32'(i);
      mem_init <= 1'b1;
    end else if (bus.mem_enable) begin
      w = was_en ? mem_idx + 1 : (bus.mem_addr - START) >> 2;
      mem_idx <= w;
      if (bus.mem_wren) mem_q[w[5:0]] <= bus.mem_d_in;
      else              bus.mem_d_out <= mem_q[w[5:0]];
    end
    was_en       <= bus.mem_enable;
    bus.mem_busy <= bus.mem_enable & ~busy_kill;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Issues one request, follows it to done, then checks the return to idle.
  task automatic do_txn(input string tag, input logic [31:0] addr, input logic [1:0] size,
                        input logic wren, input int beats, input int done_cyc, input logic exp_err);
    int cyc     = 1;
    int en_cnt  = 0;
    int rd_cnt  = 0;
    int pop_cnt = 0;
    int rd_n    = wren ? 0 : beats;
    int pop_n   = wren ? beats : 0;
    bit got     = 1'b0;
    check({tag, "_ready_before"}, 32'(bus.req_ready), 32'd1);
    bus.req_addr  = addr;
    bus.req_size  = size;
    bus.req_wren  = wren;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    while (!got && cyc <= 40) begin
      if (bus.wdata_pop) begin
        bus.wdata = 32'hA0 + 32'(pop_cnt);
        #1;
        check($sformatf("%s_d_in%0d", tag, pop_cnt), bus.mem_d_in, 32'hA0 + 32'(pop_cnt));
        pop_cnt++;
      end
      if (bus.mem_enable) begin
        check({tag, "_mem_addr"}, bus.mem_addr, addr);
        check({tag, "_acc_size"}, 32'(bus.mem_acc_size), 32'(size));
        check({tag, "_mem_wren"}, 32'(bus.mem_wren), 32'(wren));
        en_cnt++;
      end
      if (bus.rd_valid) begin
        check($sformatf("%s_rd_data%0d", tag, rd_cnt), bus.rd_data, exp_rd[rd_cnt & 15]);
        check($sformatf("%s_rd_last%0d", tag, rd_cnt), 32'(bus.rd_last), 32'(rd_cnt == rd_n - 1));
        rd_cnt++;
      end
      if (bus.done) begin
        got = 1'b1;
        check({tag, "_done_cycle"}, 32'(cyc), 32'(done_cyc));
        check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
      end else begin
        check({tag, "_ready_busy"}, 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        cyc++;
      end
    end
    if (!got) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    check({tag, "_enable_cycles"}, 32'(en_cnt), 32'(beats));
    check({tag, "_rd_count"}, 32'(rd_cnt), 32'(rd_n));
    check({tag, "_pop_count"}, 32'(pop_cnt), 32'(pop_n));
    @(negedge clk);
    check({tag, "_ready_after"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_done_after"}, 32'(bus.done), 32'd0);
    check({tag, "_rd_valid_after"}, 32'(bus.rd_valid), 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    busy_kill     = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_size  = '0;
    bus.req_wren  = 1'b0;
    bus.wdata     = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready",  32'(bus.req_ready),  32'd1);
    check("rst_mem_enable", 32'(bus.mem_enable), 32'd0);
    check("rst_wdata_pop",  32'(bus.wdata_pop),  32'd0);
    check("rst_rd_valid",   32'(bus.rd_valid),   32'd0);
    check("rst_done",       32'(bus.done),       32'd0);
    check("rst_err",        32'(bus.err),        32'd0);
    check("rst_mem_addr",   bus.mem_addr,        32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single read: one beat, data and done together in the next cycle.
    exp_rd[0] = 32'hC000_0000;
    do_txn("rd1", START, 2'b00, 1'b0, 1, 2, 1'b0);

    // Four-word write into words 4..7, then read them back.
    do_txn("wr4", START + 32'h10, 2'b01, 1'b1, 4, 5, 1'b0);
    for (int i = 0; i < 4; i++) exp_rd[i] = 32'hA0 + 32'(i);
    do_txn("rb4", START + 32'h10, 2'b01, 1'b0, 4, 5, 1'b0);

    // Sixteen-word read across the freshly written words.
    for (int i = 0; i < 16; i++)
      exp_rd[i] = (i >= 4 && i < 8) ? 32'hA0 + 32'(i - 4) : 32'hC000_0000 + 32'(i);
    do_txn("rd16", START, 2'b11, 1'b0, 16, 17, 1'b0);

    // Last legal four-word window at the top of memory.
    for (int i = 0; i < 4; i++) exp_rd[i] = 32'hC000_003C + 32'(i);
    do_txn("top_ok", START + MSIZE - 32'd16, 2'b01, 1'b0, 4, 5, 1'b0);

    // Rejected requests never enable the memory.
    do_txn("misalign", START + 32'd2, 2'b00, 1'b0, 0, 1, 1'b1);
    do_txn("below",    32'h8001_FFFC, 2'b00, 1'b0, 0, 1, 1'b1);
    do_txn("overrun",  START + MSIZE - 32'd8, 2'b01, 1'b0, 0, 1, 1'b1);

    // Reset during beat 3 of an eight-word read.
    bus.req_addr  = START;
    bus.req_size  = 2'b10;
    bus.req_wren  = 1'b0;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_enable_before", 32'(bus.mem_enable), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_enable",   32'(bus.mem_enable), 32'd0);
    check("abort_rd_valid", 32'(bus.rd_valid),   32'd0);
    check("abort_ready",    32'(bus.req_ready),  32'd1);
    check("abort_done",     32'(bus.done),       32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_no_done", 32'(bus.done), 32'd0);
    exp_rd[0] = 32'hC000_0001;
    do_txn("rd_after_rst", START + 32'd4, 2'b00, 1'b0, 1, 2, 1'b0);

    // Memory never reports busy: the burst completes and then reports an error.
    busy_kill = 1'b1;
    for (int i = 0; i < 8; i++)
      exp_rd[i] = (i >= 4) ? 32'hA0 + 32'(i - 4) : 32'hC000_0000 + 32'(i);
    do_txn("busy_err", START, 2'b10, 1'b0, 8, 9, 1'b1);
    busy_kill = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
